// File: rtl/sequence_game_ctrl.sv
// Memory-game controller: plays back a growing prefix of the pattern ROM, then checks the player's presses.
// Optional press timeout is enabled by defining SEQUENCE_TIMEOUT_EN.
module sequence_game_ctrl #(
    parameter int SHOW_CYCLES    = 25_000_000,
    parameter int GAP_CYCLES     = 12_500_000,
    parameter int TIMEOUT_CYCLES = 150_000_000,
    parameter int TIMER_W        = 28
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [6:0] buttons,
    input  logic [6:0] rom_data,
    output logic [3:0] rom_addr,
    output logic [6:0] leds,
    output logic [3:0] round,
    output logic       busy,
    output logic       win,
    output logic       lose
);

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] SHOW_FETCH   = 3'd1;
    localparam logic [2:0] SHOW_ON      = 3'd2;
    localparam logic [2:0] SHOW_OFF     = 3'd3;
    localparam logic [2:0] WAIT_FETCH   = 3'd4;
    localparam logic [2:0] WAIT_PRESS   = 3'd5;
    localparam logic [2:0] WAIT_RELEASE = 3'd6;
    localparam logic [2:0] DONE         = 3'd7;

    localparam logic [TIMER_W-1:0] SHOW_LAST    = TIMER_W'(SHOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [3:0]         LAST_ITEM    = 4'd15;

`ifdef SEQUENCE_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    logic [2:0]         state_q,    state_d;
    logic [TIMER_W-1:0] timer_q,    timer_d;
    logic [3:0]         rom_addr_q, rom_addr_d;
    logic [3:0]         round_q,    round_d;
    logic               busy_q,     busy_d;
    logic               win_q,      win_d;
    logic               lose_q,     lose_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + 1'b1;
        rom_addr_d = rom_addr_q;
        round_d    = round_q;
        busy_d     = busy_q;
        win_d      = win_q;
        lose_d     = lose_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    round_d    = '0;
                    rom_addr_d = '0;
                    win_d      = 1'b0;
                    lose_d     = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = SHOW_FETCH;
                end
            end
            SHOW_FETCH: state_d = SHOW_ON;
            SHOW_ON: begin
                if (timer_q == SHOW_LAST) state_d = SHOW_OFF;
            end
            SHOW_OFF: begin
                if (timer_q == GAP_LAST) begin
                    if (rom_addr_q < round_q) begin
                        rom_addr_d = rom_addr_q + 1'b1;
                        state_d    = SHOW_FETCH;
                    end else begin
                        rom_addr_d = '0;
                        state_d    = WAIT_FETCH;
                    end
                end
            end
            WAIT_FETCH: state_d = WAIT_PRESS;
            WAIT_PRESS: begin
                // Exact match only: pressing extra buttons alongside the right one is a miss.
                if (buttons != '0) begin
                    if (buttons == rom_data) begin
                        state_d = WAIT_RELEASE;
                    end else begin
                        lose_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end
                end
`ifdef SEQUENCE_TIMEOUT_EN
                else if (timer_q == TIMEOUT_LAST) begin
                    lose_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
`endif
            end
            WAIT_RELEASE: begin
                if (buttons == '0) begin
                    if (rom_addr_q < round_q) begin
                        rom_addr_d = rom_addr_q + 1'b1;
                        state_d    = WAIT_FETCH;
                    end else if (round_q == LAST_ITEM) begin
                        win_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        round_d    = round_q + 1'b1;
                        rom_addr_d = '0;
                        state_d    = SHOW_FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Each phase's length is measured from its own entry.
        if (state_d != state_q) timer_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            rom_addr_q <= '0;
            round_q    <= '0;
            busy_q     <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            rom_addr_q <= rom_addr_d;
            round_q    <= round_d;
            busy_q     <= busy_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
        end
    end

    always_comb begin
        leds = '0;
        if (state_q == SHOW_ON) leds = rom_data;
    end

    assign rom_addr = rom_addr_q;
    assign round    = round_q;
    assign busy     = busy_q;
    assign win      = win_q;
    assign lose     = lose_q;

endmodule

// File: tb/tb_sequence_game_ctrl.sv
// Bench for sequence_game_ctrl: registered ROM model, random pattern, spec-level timing expectations.
module tb_sequence_game_ctrl;

    localparam int SHOW = 4;
    localparam int GAP  = 2;
    localparam int TOUT = 10;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [6:0] buttons;
    logic [6:0] rom_data;
    logic [3:0] rom_addr;
    logic [6:0] leds;
    logic [3:0] round;
    logic       busy;
    logic       win;
    logic       lose;

    logic [6:0] seq [16];
    int vectors    = 0;
    int miscompares = 0;

    sequence_game_ctrl #(
        .SHOW_CYCLES   (SHOW),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .buttons (buttons),
        .rom_data(rom_data),
        .rom_addr(rom_addr),
        .leds    (leds),
        .round   (round),
        .busy    (busy),
        .win     (win),
        .lose    (lose)
    );

    always #5 clock = ~clock;

    // Pattern ROM: data appears one cycle after the address.
    always @(posedge clock) rom_data <= seq[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Entered in the fetch cycle of item 0; leaves the DUT just entered the press-wait phase.
    task automatic play_back(input int r, input bit poke_start);
        for (int i = 0; i <= r; i++) begin
            check("fetch_leds", leds, 0);
            check("fetch_addr", rom_addr, i);
            check("fetch_round", round, r);
            check("fetch_busy", busy, 1);
            for (int k = 0; k < SHOW; k++) begin
                if (poke_start && i == 0 && k == 0) start = 1'b1;
                tick();
                start = 1'b0;
                check("show_leds", leds, seq[i]);
            end
            for (int k = 0; k < GAP; k++) begin
                tick();
                check("gap_leds", leds, 0);
            end
            tick();
        end
        check("wfetch_leds", leds, 0);
        check("wfetch_addr", rom_addr, 0);
        tick();
    endtask

    // Player answers all items of round r correctly, with random think and hold times.
    task automatic answer(input int r);
        for (int j = 0; j <= r; j++) begin
            int idle;
            int hold;
            idle = $urandom_range(4, 0);
            hold = $urandom_range(2, 0);
            repeat (idle) begin
                tick();
                check("think_lose", lose, 0);
            end
            buttons = seq[j];
            tick();
            check("press_busy", busy, 1);
            check("press_lose", lose, 0);
            repeat (hold) begin
                tick();
                check("hold_addr", rom_addr, j);
            end
            buttons = '0;
            tick();
            if (j < r) begin
                check("next_addr", rom_addr, j + 1);
                check("next_leds", leds, 0);
                tick();
            end else if (r == 15) begin
                check("win", win, 1);
                check("win_busy", busy, 0);
                check("win_round", round, 15);
                check("win_lose", lose, 0);
            end else begin
                check("adv_round", round, r + 1);
                check("adv_addr", rom_addr, 0);
                check("adv_busy", busy, 1);
            end
        end
    endtask

    initial begin
        seq[0] = 7'b0010000;
        seq[1] = 7'b0100000;
        for (int i = 2; i < 16; i++) seq[i] = 7'(1) << $urandom_range(6, 0);

        reset_n = 1'b0;
        start   = 1'b0;
        buttons = '0;
        #12;
        check("rst_addr", rom_addr, 0);
        check("rst_round", round, 0);
        check("rst_leds", leds, 0);
        check("rst_busy", busy, 0);
        check("rst_win", win, 0);
        check("rst_lose", lose, 0);
        reset_n = 1'b1;
        tick();
        tick();
        check("idle_busy", busy, 0);

        // Full winning game; start and a button together in IDLE, and a start poke while busy.
        start   = 1'b1;
        buttons = seq[0];
        tick();
        start   = 1'b0;
        buttons = '0;
        check("start_busy", busy, 1);
        check("start_win", win, 0);
        check("start_lose", lose, 0);
        for (int r = 0; r < 16; r++) begin
            play_back(r, r == 1);
            answer(r);
        end
        buttons = 7'b0000100;
        repeat (3) tick();
        buttons = '0;
        check("win_held", win, 1);
        check("done_busy", busy, 0);
        check("done_lose", lose, 0);

        // Wrong single press.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_win", win, 0);
        check("restart_busy", busy, 1);
        play_back(0, 1'b0);
        buttons = 7'b0000001;
        tick();
        check("miss_lose", lose, 1);
        check("miss_busy", busy, 0);
        check("miss_win", win, 0);
        buttons = '0;
        repeat (5) tick();
        check("lose_held", lose, 1);

        // Multi-press containing the right item in round 1.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_lose", lose, 0);
        play_back(0, 1'b0);
        answer(0);
        play_back(1, 1'b0);
        buttons = seq[0] | seq[1];
        tick();
        buttons = '0;
        check("multi_lose", lose, 1);
        check("multi_busy", busy, 0);

        // Idle player in the press-wait phase.
        start = 1'b1;
        tick();
        start = 1'b0;
        play_back(0, 1'b0);
`ifdef SEQUENCE_TIMEOUT_EN
        repeat (TOUT - 1) tick();
        check("tout_early", lose, 0);
        tick();
        check("tout_lose", lose, 1);
        check("tout_busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
`else
        repeat (100) tick();
        check("notout_lose", lose, 0);
        check("notout_busy", busy, 1);
        answer(0);
`endif

        // Asynchronous reset in the middle of a lit item.
        tick();
        check("pre_rst_leds", leds, seq[0]);
        reset_n = 1'b0;
        #1;
        check("arst_leds", leds, 0);
        check("arst_busy", busy, 0);
        check("arst_addr", rom_addr, 0);
        check("arst_round", round, 0);
        #3;
        reset_n = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
